// File: rtl/xec_pkg.sv
// Shared definitions for the serial word loader: FSM state encoding and a
// constant-foldable clog2 used to size counters from parameters.
package xec_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// Serial input and committed-word output bundle between a bit source and the
// word loader; the loader sits on the slave side.
interface serial_word_loader_if #(
    parameter int WIDTH = 8
);
    logic             SI;
    logic             SV;
    logic             SF;
    logic [WIDTH-1:0] D;
    logic             CE;
    logic             BUSY;
    logic             ERR;

    modport master (output SI, SV, SF, input D, CE, BUSY, ERR);
    modport slave  (input SI, SV, SF, output D, CE, BUSY, ERR);
endinterface

// File: rtl/gap_timer.sv
// Counts idle cycles inside a frame and flags the cycle on which the gap
// reaches GAP_MAX; a valid bit or leaving the frame clears the count.
module gap_timer
    import xec_pkg::*;
#(
    parameter int GAP_MAX = 15
) (
    input  logic C,
    input  logic CLR_N,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int GW = (clog2(GAP_MAX + 1) < 1) ? 1 : clog2(GAP_MAX + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_MAX > 0) ? GAP_MAX - 1 : 0);

    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;

    always_comb begin
        gap_d = gap_q;
        if (!run || kick) begin
            gap_d = '0;
        end else if (gap_q != '1) begin
            gap_d = gap_q + GW'(1);
        end
    end

    // Combinational so the loader can register ERR on the very edge that
    // would take the count to GAP_MAX.
    always_comb begin
        expire = (GAP_MAX != 0) && run && !kick && (gap_q >= GAP_LAST);
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Assembles a framed serial bit stream into a WIDTH-bit word and presents it
// with a one-cycle CE strobe; aborted frames never reach D.
module serial_word_loader
    import xec_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] INIT      = '0,
    parameter bit               MSB_FIRST = 1'b1,
    parameter int               GAP_MAX   = 15
) (
    input  logic                C,
    input  logic                CLR_N,
    serial_word_loader_if.slave bus
);

    localparam int CW = clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             ce_q, ce_d;
    logic             err_q, err_d;
    logic             expire;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;

    // Widening by one bit keeps both shift directions legal for WIDTH == 1.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                  input logic             bit_i);
        logic [WIDTH:0] wide;
        if (MSB_FIRST) begin
            wide = {base, bit_i};
        end else begin
            wide = {bit_i, base} >> 1;
        end
        return wide[WIDTH-1:0];
    endfunction

    gap_timer #(
        .GAP_MAX (GAP_MAX)
    ) u_gap_timer (
        .C      (C),
        .CLR_N  (CLR_N),
        .run    (state_q == ST_SHIFT),
        .kick   (bus.SV),
        .expire (expire)
    );

    always_comb begin
        shifted    = shift_in(sh_q, bus.SI);
        first_word = shift_in('0, bus.SI);
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        d_d        = d_q;
        ce_d       = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // SV without SF is a stray bit and is dropped silently.
                if (bus.SV && bus.SF) begin
                    if (WIDTH == 1) begin
                        d_d  = first_word;
                        ce_d = 1'b1;
                    end else begin
                        sh_d    = first_word;
                        cnt_d   = CW'(1);
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.SV && bus.SF) begin
                    err_d = 1'b1;
                    sh_d  = first_word;
                    cnt_d = CW'(1);
                end else if (bus.SV) begin
                    if (cnt_q == CNT_LAST) begin
                        d_d     = shifted;
                        ce_d    = 1'b1;
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end else begin
                        sh_d  = shifted;
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    sh_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sh_d    = '0;
            end
        endcase
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            d_q     <= INIT;
            ce_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            d_q     <= d_d;
            ce_q    <= ce_d;
            err_q   <= err_d;
        end
    end

    assign bus.D    = d_q;
    assign bus.CE   = ce_q;
    assign bus.BUSY = (state_q == ST_SHIFT);
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed bench for serial_word_loader: four configurations share one
// stimulus stream, gated per test, and a scoreboard checks every CE/ERR event.
module tb_serial_word_loader;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       si, sv, sf;
    logic [3:0] en;
    int         tests = 0;
    int         fails = 0;

    typedef struct {
        int         dut;
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_word_loader_if #(.WIDTH(8)) bus0 ();
    serial_word_loader_if #(.WIDTH(8)) bus1 ();
    serial_word_loader_if #(.WIDTH(8)) bus2 ();
    serial_word_loader_if #(.WIDTH(8)) bus3 ();

    assign bus0.SI = si; assign bus0.SF = sf; assign bus0.SV = sv & en[0];
    assign bus1.SI = si; assign bus1.SF = sf; assign bus1.SV = sv & en[1];
    assign bus2.SI = si; assign bus2.SF = sf; assign bus2.SV = sv & en[2];
    assign bus3.SI = si; assign bus3.SF = sf; assign bus3.SV = sv & en[3];

    serial_word_loader #(.WIDTH(8), .INIT(8'h00), .MSB_FIRST(1'b1), .GAP_MAX(15))
        u_dut0 (.C(clk), .CLR_N(clr_n), .bus(bus0));
    serial_word_loader #(.WIDTH(8), .INIT(8'h00), .MSB_FIRST(1'b0), .GAP_MAX(15))
        u_dut1 (.C(clk), .CLR_N(clr_n), .bus(bus1));
    serial_word_loader #(.WIDTH(8), .INIT(8'h00), .MSB_FIRST(1'b1), .GAP_MAX(4))
        u_dut2 (.C(clk), .CLR_N(clr_n), .bus(bus2));
    serial_word_loader #(.WIDTH(8), .INIT(8'h5A), .MSB_FIRST(1'b1), .GAP_MAX(15))
        u_dut3 (.C(clk), .CLR_N(clr_n), .bus(bus3));

    logic [7:0] d_w[4];
    logic       ce_w[4];
    logic       err_w[4];
    logic       busy_w[4];

    assign d_w[0] = bus0.D; assign ce_w[0] = bus0.CE; assign err_w[0] = bus0.ERR; assign busy_w[0] = bus0.BUSY;
    assign d_w[1] = bus1.D; assign ce_w[1] = bus1.CE; assign err_w[1] = bus1.ERR; assign busy_w[1] = bus1.BUSY;
    assign d_w[2] = bus2.D; assign ce_w[2] = bus2.CE; assign err_w[2] = bus2.ERR; assign busy_w[2] = bus2.BUSY;
    assign d_w[3] = bus3.D; assign ce_w[3] = bus3.CE; assign err_w[3] = bus3.ERR; assign busy_w[3] = bus3.BUSY;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic f, input logic b, input logic v);
        sf = f;
        si = b;
        sv = v;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ce(input int k, input logic [7:0] v);
        exp_t e;
        e.dut = k; e.is_err = 1'b0; e.data = v;
        sb.push_back(e);
    endtask

    task automatic push_err(input int k);
        exp_t e;
        e.dut = k; e.is_err = 1'b1; e.data = 8'h00;
        sb.push_back(e);
    endtask

    // Every CE or ERR pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            if (ce_w[k] || err_w[k]) begin
                $display("[TB] t=%0t dut%0d %s D=%h", $time, k, ce_w[k] ? "CE" : "ERR", d_w[k]);
                chk($sformatf("ce_err_exclusive_dut%0d", k), {63'b0, ce_w[k] & err_w[k]}, 64'd0);
                tests++;
                assert (sb.size() != 0) else begin
                    fails++;
                    $error("FAIL unexpected_event dut%0d observed=ce%0b/err%0b expected=none", k, ce_w[k], err_w[k]);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("event_dut", k, e.dut);
                    chk("event_is_err", {63'b0, err_w[k]}, {63'b0, e.is_err});
                    if (!e.is_err) chk("event_data", d_w[k], e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        clr_n = 1'b0; si = 1'b0; sv = 1'b0; sf = 1'b0; en = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_d_dut%0d", k), d_w[k], (k == 3) ? 8'h5A : 8'h00);
            chk($sformatf("reset_ce_dut%0d", k), ce_w[k], 0);
            chk($sformatf("reset_busy_dut%0d", k), busy_w[k], 0);
            chk($sformatf("reset_err_dut%0d", k), err_w[k], 0);
        end
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;

        // Early restart on dut0 while D still holds INIT.
        en = 4'b0001;
        push_err(0);
        push_ce(0, 8'hFF);
        w = 8'b10110000;
        for (int i = 0; i < 5; i++) step(i == 0, w[7-i], 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("restart_err", err_w[0], 1);
        chk("restart_d_unchanged", d_w[0], 8'h00);
        chk("restart_busy", busy_w[0], 1);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i < 6) chk("restart_no_ce", ce_w[0], 0);
        end
        chk("restart_ce", ce_w[0], 1);
        chk("restart_d", d_w[0], 8'hFF);
        step(1'b0, 1'b0, 1'b0);

        // Basic MSB-first frame with BUSY and CE timing.
        push_ce(0, 8'hA5);
        w = 8'b10100101;
        for (int i = 0; i < 8; i++) begin
            step(i == 0, w[7-i], 1'b1);
            if (i < 7) begin
                chk("basic_busy", busy_w[0], 1);
                chk("basic_no_ce", ce_w[0], 0);
            end
        end
        chk("basic_ce", ce_w[0], 1);
        chk("basic_d", d_w[0], 8'hA5);
        chk("basic_busy_done", busy_w[0], 0);
        chk("basic_err", err_w[0], 0);
        step(1'b0, 1'b0, 1'b0);
        chk("basic_ce_one_cycle", ce_w[0], 0);

        // LSB-first with a 3-cycle gap inside the frame.
        en = 4'b0010;
        push_ce(1, 8'hA5);
        for (int i = 0; i < 4; i++) step(i == 0, w[7-i], 1'b1);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            chk("lsb_gap_busy", busy_w[1], 1);
        end
        for (int i = 4; i < 8; i++) step(1'b0, w[7-i], 1'b1);
        chk("lsb_ce", ce_w[1], 1);
        chk("lsb_d", d_w[1], 8'hA5);
        step(1'b0, 1'b0, 1'b0);

        // Timeout with GAP_MAX=4, then stray bits, then recovery.
        en = 4'b0100;
        push_err(2);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("timeout_no_err_yet", err_w[2], 0);
            chk("timeout_busy_yet", busy_w[2], 1);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("timeout_err", err_w[2], 1);
        chk("timeout_busy", busy_w[2], 0);
        chk("timeout_d", d_w[2], 8'h00);
        chk("timeout_ce", ce_w[2], 0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1);
            chk("stray_busy", busy_w[2], 0);
            chk("stray_err", err_w[2], 0);
        end
        push_ce(2, 8'h81);
        w = 8'h81;
        for (int i = 0; i < 8; i++) step(i == 0, w[7-i], 1'b1);
        chk("timeout_recover_d", d_w[2], 8'h81);
        step(1'b0, 1'b0, 1'b0);

        // Back-to-back frames: second SF lands on the CE cycle.
        en = 4'b0001;
        push_ce(0, 8'h3C);
        push_ce(0, 8'hC3);
        for (int i = 0; i < 16; i++) begin
            w = (i < 8) ? 8'h3C : 8'hC3;
            step(i == 0 || i == 8, w[7-(i%8)], 1'b1);
            if (i == 7) begin
                chk("b2b_ce1", ce_w[0], 1);
                chk("b2b_d1", d_w[0], 8'h3C);
            end else if (i > 7 && i < 15) begin
                chk("b2b_gap_no_ce", ce_w[0], 0);
                chk("b2b_no_err", err_w[0], 0);
            end
        end
        chk("b2b_ce2", ce_w[0], 1);
        chk("b2b_d2", d_w[0], 8'hC3);
        step(1'b0, 1'b0, 1'b0);

        // Asynchronous clear mid-frame on dut3.
        en = 4'b1000;
        push_ce(3, 8'h01);
        for (int i = 0; i < 4; i++) step(i == 0, 1'b0, 1'b1);
        chk("midreset_busy_before", busy_w[3], 1);
        #2 clr_n = 1'b0;
        #1;
        chk("midreset_d", d_w[3], 8'h5A);
        chk("midreset_ce", ce_w[3], 0);
        chk("midreset_busy", busy_w[3], 0);
        sv = 1'b0; sf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) clr_n = 1'b1;
        @(posedge clk); #1;
        chk("release_busy", busy_w[3], 0);
        chk("release_d", d_w[3], 8'h5A);
        w = 8'h01;
        for (int i = 0; i < 8; i++) step(i == 0, w[7-i], 1'b1);
        chk("post_reset_ce", ce_w[3], 1);
        chk("post_reset_d", d_w[3], 8'h01);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
